// File: rtl/mod_exp_ctrl_pkg.sv
// Shared definitions for the modular exponentiation controller and its
// Montgomery multiplier.
package mod_exp_ctrl_pkg;

  localparam int N_WIDTH_DEF = 512;
  localparam int E_WIDTH_DEF = 512;
  localparam int CNT_W_DEF   = 10;

  typedef enum logic [3:0] {
    IDLE,
    TOMONT,
    W_TOMONT,
    SQ,
    W_SQ,
    MUL,
    W_MUL,
    NEXT,
    FROMMONT,
    W_FROMMONT
  } state_t;

endpackage

// File: rtl/mod_exp_ctrl_mont.sv
// Montgomery multiplier: result = a*b*2^-N_WIDTH mod m, fully reduced.
// Consumes BPC bits of operand a per clock; done pulses with the result.
module mod_exp_ctrl_mont
  import mod_exp_ctrl_pkg::*;
#(
  parameter int N_WIDTH = N_WIDTH_DEF,
  parameter int BPC     = 64
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_WIDTH-1:0] in_a,
  input  logic [N_WIDTH-1:0] in_b,
  input  logic [N_WIDTH-1:0] in_m,
  output logic [N_WIDTH-1:0] result,
  output logic               done
);

  localparam int              ITER = N_WIDTH / BPC;
  localparam int              IT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IT_W-1:0] LAST = IT_W'(ITER - 1);

  logic [N_WIDTH-1:0] r_a;
  logic [N_WIDTH-1:0] r_b;
  logic [N_WIDTH-1:0] r_m;
  logic [N_WIDTH-1:0] r_result;
  logic [N_WIDTH+1:0] r_t;
  logic [N_WIDTH+1:0] w_t;
  logic [IT_W-1:0]    r_it;
  logic               r_busy;
  logic               r_done;

  // The running sum stays below 2m, so one conditional subtraction suffices.
  function automatic logic [N_WIDTH-1:0] final_sub(input logic [N_WIDTH+1:0] t,
                                                   input logic [N_WIDTH-1:0] m);
    return (t >= {2'b00, m}) ? N_WIDTH'(t - {2'b00, m}) : N_WIDTH'(t);
  endfunction

  always_comb begin
    w_t = r_t;
    for (int i = 0; i < BPC; i++) begin
      if (r_a[i]) w_t = w_t + {2'b00, r_b};
      if (w_t[0]) w_t = w_t + {2'b00, r_m};
      w_t = w_t >> 1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_t      <= '0;
      r_it     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (start) begin
          r_a    <= in_a;
          r_b    <= in_b;
          r_m    <= in_m;
          r_t    <= '0;
          r_it   <= '0;
          r_busy <= 1'b1;
        end
      end else begin
        r_t <= w_t;
        r_a <= r_a >> BPC;
        if (r_it == LAST) begin
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_result <= final_sub(w_t, r_m);
        end else begin
          r_it <= r_it + 1'b1;
        end
      end
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply modular exponentiation in the Montgomery
// domain, sequencing a single shared Montgomery multiplier.
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int N_WIDTH = N_WIDTH_DEF,
  parameter int E_WIDTH = E_WIDTH_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [N_WIDTH-1:0] in_x,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [N_WIDTH-1:0] in_m,
  input  logic [N_WIDTH-1:0] in_r,
  input  logic [N_WIDTH-1:0] in_r2,
  output logic [N_WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);

  state_t             r_state;
  state_t             w_next;
  logic [N_WIDTH-1:0] r_x;
  logic [N_WIDTH-1:0] r_m;
  logic [N_WIDTH-1:0] r_r2;
  logic [N_WIDTH-1:0] r_a;
  logic [N_WIDTH-1:0] r_xm;
  logic [N_WIDTH-1:0] r_result;
  logic [E_WIDTH-1:0] r_e;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;

  logic               w_mm_start;
  logic               w_mm_done;
  logic [N_WIDTH-1:0] w_mm_a;
  logic [N_WIDTH-1:0] w_mm_b;
  logic [N_WIDTH-1:0] w_mm_result;

  mod_exp_ctrl_mont #(
    .N_WIDTH (N_WIDTH)
  ) u_mont (
    .clk    (clk),
    .resetn (resetn),
    .start  (w_mm_start),
    .in_a   (w_mm_a),
    .in_b   (w_mm_b),
    .in_m   (r_m),
    .result (w_mm_result),
    .done   (w_mm_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Operands are held through each WAIT state so the multiplier never sees a glitch.
  always_comb begin
    w_next     = r_state;
    w_mm_start = 1'b0;
    w_mm_a     = r_a;
    w_mm_b     = r_a;
    case (r_state)
      IDLE:       if (start) w_next = TOMONT;
      TOMONT: begin
        w_mm_start = 1'b1;
        w_mm_a     = r_x;
        w_mm_b     = r_r2;
        w_next     = W_TOMONT;
      end
      W_TOMONT: begin
        w_mm_a = r_x;
        w_mm_b = r_r2;
        if (w_mm_done) w_next = SQ;
      end
      SQ: begin
        w_mm_start = 1'b1;
        w_next     = W_SQ;
      end
      W_SQ:       if (w_mm_done) w_next = r_e[E_WIDTH-1] ? MUL : NEXT;
      MUL: begin
        w_mm_start = 1'b1;
        w_mm_b     = r_xm;
        w_next     = W_MUL;
      end
      W_MUL: begin
        w_mm_b = r_xm;
        if (w_mm_done) w_next = NEXT;
      end
      NEXT:       w_next = (r_cnt == '0) ? FROMMONT : SQ;
      FROMMONT: begin
        w_mm_start = 1'b1;
        w_mm_b     = N_WIDTH'(1);
        w_next     = W_FROMMONT;
      end
      W_FROMMONT: begin
        w_mm_b = N_WIDTH'(1);
        if (w_mm_done) w_next = IDLE;
      end
      default:    w_next = IDLE;
    endcase
  end

  // The exponent shifts left alongside the counter, so its MSB is always e[counter].
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_x      <= '0;
      r_m      <= '0;
      r_r2     <= '0;
      r_a      <= '0;
      r_xm     <= '0;
      r_e      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x   <= in_x;
            r_e   <= in_e;
            r_m   <= in_m;
            r_r2  <= in_r2;
            r_a   <= in_r;
            r_cnt <= CNT_W'(E_WIDTH - 1);
          end
        end
        W_TOMONT:    if (w_mm_done) r_xm <= w_mm_result;
        W_SQ, W_MUL: if (w_mm_done) r_a <= w_mm_result;
        NEXT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            r_e   <= {r_e[E_WIDTH-2:0], 1'b0};
          end
        end
        W_FROMMONT: begin
          if (w_mm_done) begin
            r_result <= w_mm_result;
            r_done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl: expected x^e mod M from a plain
// shift-and-add reference model, compared as each done pulse is observed.
`timescale 1ns/1ps
module tb_mod_exp_ctrl;
  import mod_exp_ctrl_pkg::*;

  localparam int NW     = 512;
  localparam int EW     = 512;
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [NW-1:0] in_x;
  logic [EW-1:0] in_e;
  logic [NW-1:0] in_m;
  logic [NW-1:0] in_r;
  logic [NW-1:0] in_r2;
  logic [NW-1:0] result;
  logic          done;
  logic          busy;

  always #5 clk = ~clk;

  mod_exp_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_x   (in_x),
    .in_e   (in_e),
    .in_m   (in_m),
    .in_r   (in_r),
    .in_r2  (in_r2),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  int            n_checks   = 0;
  int            n_pass     = 0;
  int            done_cnt   = 0;
  int            mm_starts  = 0;
  int            mul_starts = 0;
  logic [NW-1:0] exp_q[$];
  logic [NW-1:0] obs_q[$];

  always @(negedge clk) begin
    if (done === 1'b1) begin
      obs_q.push_back(result);
      done_cnt++;
    end
    if (dut.w_mm_start === 1'b1) mm_starts++;
    if (dut.r_state == MUL) mul_starts++;
  end

  function automatic logic [NW-1:0] mod_mul(input logic [NW-1:0] a, input logic [NW-1:0] b,
                                            input logic [NW-1:0] m);
    logic [NW+1:0] acc;
    acc = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      acc = acc << 1;
      if (acc >= {2'b00, m}) acc = acc - {2'b00, m};
      if (b[i]) begin
        acc = acc + {2'b00, a};
        if (acc >= {2'b00, m}) acc = acc - {2'b00, m};
      end
    end
    return NW'(acc);
  endfunction

  function automatic logic [NW-1:0] pow_mod(input logic [NW-1:0] x, input logic [EW-1:0] e,
                                            input logic [NW-1:0] m);
    logic [NW-1:0] res;
    res = NW'(1);
    for (int i = EW - 1; i >= 0; i--) begin
      res = mod_mul(res, res, m);
      if (e[i]) res = mod_mul(res, x, m);
    end
    return res;
  endfunction

  function automatic logic [NW-1:0] pow2mod(input int k, input logic [NW-1:0] m);
    logic [NW:0] v;
    v = (NW + 1)'(1);
    for (int i = 0; i < k; i++) begin
      v = v << 1;
      if (v >= {1'b0, m}) v = v - {1'b0, m};
    end
    return NW'(v);
  endfunction

  function automatic logic [NW-1:0] rand_wide();
    logic [NW-1:0] v;
    v = '0;
    for (int i = 0; i < NW / 32; i++) v = (v << 32) | NW'($urandom());
    return v;
  endfunction

  task automatic drive_start(input logic [NW-1:0] x, input logic [EW-1:0] e,
                             input logic [NW-1:0] m);
    @(negedge clk);
    in_x  = x;
    in_e  = e;
    in_m  = m;
    in_r  = pow2mod(NW, m);
    in_r2 = pow2mod(2 * NW, m);
    start = 1'b1;
    exp_q.push_back(pow_mod(x, e, m));
    @(negedge clk);
    start = 1'b0;
    in_x  = rand_wide();
    in_e  = rand_wide();
    in_m  = rand_wide();
    in_r  = rand_wide();
    in_r2 = rand_wide();
  endtask

  task automatic wait_done(output int busy_low, output bit timeout);
    int n;
    n        = 0;
    busy_low = 0;
    while (done !== 1'b1 && n < BUDGET) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      n++;
    end
    timeout = (done !== 1'b1);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (result !== '0) $display("FAIL reset_result: got %0h want 0", result);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int            s0, m0, d0, bl;
    bit            to;
    logic [NW-1:0] want, got;
    s0 = mm_starts;
    m0 = mul_starts;
    d0 = done_cnt;
    drive_start(NW'(3), EW'(5), NW'(13));
    wait_done(bl, to);
    n_checks++;
    if (to) $display("FAIL basic_timeout: done not seen within %0d cycles", BUDGET);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", done);
    else n_pass++;
    want = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    got  = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
    n_checks++;
    if (got !== want) $display("FAIL basic_result: got %0h want %0h", got, want);
    else n_pass++;
    n_checks++;
    if (bl !== 0) $display("FAIL basic_busy_held: busy low %0d cycles want 0", bl);
    else n_pass++;
    n_checks++;
    if (mm_starts - s0 !== 2 + EW + 2)
      $display("FAIL basic_mm_starts: got %0d want %0d", mm_starts - s0, 2 + EW + 2);
    else n_pass++;
    n_checks++;
    if (mul_starts - m0 !== 2) $display("FAIL basic_mul_starts: got %0d want 2", mul_starts - m0);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_pow2();
    int            m0, bl;
    bit            to;
    logic [NW-1:0] want, got;
    m0 = mul_starts;
    drive_start(NW'(2), EW'(16), NW'(13));
    wait_done(bl, to);
    n_checks++;
    if (to) $display("FAIL pow2_timeout: done not seen within %0d cycles", BUDGET);
    else n_pass++;
    @(negedge clk);
    want = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    got  = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
    n_checks++;
    if (got !== want) $display("FAIL pow2_result: got %0h want %0h", got, want);
    else n_pass++;
    n_checks++;
    if (mul_starts - m0 !== 1) $display("FAIL pow2_mul_starts: got %0d want 1", mul_starts - m0);
    else n_pass++;
  endtask

  task automatic test_e_zero();
    int            s0, m0, bl;
    bit            to;
    logic [NW-1:0] want, got;
    s0 = mm_starts;
    m0 = mul_starts;
    drive_start(NW'(7), EW'(0), NW'(13));
    wait_done(bl, to);
    n_checks++;
    if (to) $display("FAIL ezero_timeout: done not seen within %0d cycles", BUDGET);
    else n_pass++;
    @(negedge clk);
    want = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    got  = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
    n_checks++;
    if (got !== want) $display("FAIL ezero_result: got %0h want %0h", got, want);
    else n_pass++;
    n_checks++;
    if (mul_starts - m0 !== 0) $display("FAIL ezero_mul_starts: got %0d want 0", mul_starts - m0);
    else n_pass++;
    n_checks++;
    if (mm_starts - s0 !== 2 + EW)
      $display("FAIL ezero_mm_starts: got %0d want %0d", mm_starts - s0, 2 + EW);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int            d0, bl;
    bit            to;
    logic [NW-1:0] m, x, want, got;
    logic [EW-1:0] e;
    d0 = done_cnt;
    for (int k = 0; k < 2; k++) begin
      m         = rand_wide();
      m[NW-1]   = 1'b1;
      m[0]      = 1'b1;
      x         = rand_wide() & (m >> 1);
      e         = rand_wide();
      e[EW-1]   = 1'b1;
      drive_start(x, e, m);
      wait_done(bl, to);
      n_checks++;
      if (to) $display("FAIL b2b_timeout_%0d: done not seen within %0d cycles", k, BUDGET);
      else n_pass++;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      want = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      got  = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
      n_checks++;
      if (got !== want) $display("FAIL b2b_result_%0d: got %0h want %0h", k, got, want);
      else n_pass++;
    end
    n_checks++;
    if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int            d0, bl;
    bit            to;
    logic [NW-1:0] want, got;
    d0 = done_cnt;
    drive_start(NW'(3), EW'(5), NW'(13));
    repeat (40) @(negedge clk);
    in_x  = NW'(2);
    in_e  = EW'(16);
    in_m  = NW'(13);
    in_r  = pow2mod(NW, NW'(13));
    in_r2 = pow2mod(2 * NW, NW'(13));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(bl, to);
    n_checks++;
    if (to) $display("FAIL busy_start_timeout: done not seen within %0d cycles", BUDGET);
    else n_pass++;
    repeat (100) @(negedge clk);
    want = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    got  = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
    n_checks++;
    if (got !== want) $display("FAIL busy_start_result: got %0h want %0h", got, want);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 !== 1) $display("FAIL busy_start_done_count: got %0d want 1", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL busy_start_idle_after: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int            d0, bl;
    bit            to;
    logic [NW-1:0] want, got;
    d0 = done_cnt;
    drive_start(NW'(3), EW'(5), NW'(13));
    repeat (3000) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL midrst_busy_before: got %b want 1", busy);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (result !== '0) $display("FAIL midrst_result: got %0h want 0", result);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL midrst_done: got %b want 0", done);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy);
    else n_pass++;
    exp_q.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    n_checks++;
    if (done_cnt - d0 !== 0) $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0);
    else n_pass++;
    drive_start(NW'(3), EW'(5), NW'(13));
    wait_done(bl, to);
    n_checks++;
    if (to) $display("FAIL midrst_timeout: done not seen within %0d cycles", BUDGET);
    else n_pass++;
    @(negedge clk);
    want = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
    got  = obs_q.size() > 0 ? obs_q.pop_front() : 'x;
    n_checks++;
    if (got !== want) $display("FAIL midrst_fresh_result: got %0h want %0h", got, want);
    else n_pass++;
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    in_x   = '0;
    in_e   = '0;
    in_m   = '0;
    in_r   = '0;
    in_r2  = '0;
    test_reset();
    test_basic();
    test_pow2();
    test_e_zero();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
